// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 keyboard receiver.
package ps2_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } ps2_state_t;

    localparam logic [7:0] PS2_EXT = 8'hE0;
    localparam logic [7:0] PS2_BRK = 8'hF0;

    localparam int KEY_TOGGLE  = 10;
    localparam int KEY_PRESSED = 9;
    localparam int KEY_EXT     = 8;

endpackage

// File: rtl/ps2_glitch_filter.sv
// 2-FF synchronizer followed by a run-length filter; emits a one-cycle pulse
// when the filtered level falls 1->0.
module ps2_glitch_filter #(
    parameter int FILTER_LEN = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_pin,
    output logic o_level,
    output logic o_fall
);

    logic [1:0] r_sync;
    logic [3:0] r_cnt;
    logic       r_level;
    logic       r_fall;

    // r_cnt counts consecutive synchronized samples that disagree with r_level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync  <= 2'b11;
            r_cnt   <= 4'd0;
            r_level <= 1'b1;
            r_fall  <= 1'b0;
        end else begin
            r_sync <= {r_sync[0], i_pin};
            r_fall <= 1'b0;
            if (r_sync[1] != r_level) begin
                if (r_cnt == 4'(FILTER_LEN - 1)) begin
                    r_level <= r_sync[1];
                    r_cnt   <= 4'd0;
                    r_fall  <= ~r_sync[1];
                end else begin
                    r_cnt <= r_cnt + 4'd1;
                end
            end else begin
                r_cnt <= 4'd0;
            end
        end
    end

    assign o_level = r_level;
    assign o_fall  = r_fall;

endmodule

// File: rtl/ps2_key_rx.sv
// PS/2 keyboard frame receiver producing the toggle-strobed 11-bit key word,
// with E0/F0 prefix folding and stalled-frame recovery.
module ps2_key_rx
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN = 4,
    parameter int TIMEOUT    = 24000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ps2_clk,
    input  logic        ps2_data,
    output logic [10:0] ps2_key,
    output logic        key_stb,
    output logic        frame_err,
    output logic [1:0]  o_dbg_state,
    output logic        o_dbg_filt_clk
);

    localparam int TW = $clog2(TIMEOUT + 1);

    ps2_state_t  r_state;
    ps2_state_t  w_state_nxt;
    logic [1:0]  r_data_sync;
    logic [7:0]  r_shift;
    logic [2:0]  r_bitcnt;
    logic        r_parity;
    logic        r_ext;
    logic        r_brk;
    logic [TW-1:0] r_tmo;
    logic [10:0] r_key;
    logic        r_key_stb;
    logic        r_frame_err;

    logic w_fall;
    logic w_clk_level;
    logic w_data;
    logic w_timeout;
    logic w_stop_edge;
    logic w_good;
    logic w_bad;

    ps2_glitch_filter #(
        .FILTER_LEN (FILTER_LEN)
    ) u_clk_filter (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_pin   (ps2_clk),
        .o_level (w_clk_level),
        .o_fall  (w_fall)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_data_sync <= 2'b11;
        else        r_data_sync <= {r_data_sync[0], ps2_data};
    end

    assign w_data = r_data_sync[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    // An edge in the same cycle as the timeout wins: the frame keeps going.
    always_comb begin
        w_state_nxt = r_state;
        w_timeout   = (r_state != IDLE) && !w_fall && (r_tmo == TW'(TIMEOUT));
        w_stop_edge = (r_state == STOP) && w_fall;
        w_good      = w_stop_edge && w_data && (^{r_shift, r_parity});
        w_bad       = w_stop_edge && !w_good;
        case (r_state)
            IDLE:    if (w_fall && !w_data)           w_state_nxt = DATA;
            DATA:    if (w_fall && r_bitcnt == 3'd7)  w_state_nxt = PARITY;
            PARITY:  if (w_fall)                      w_state_nxt = STOP;
            STOP:    if (w_fall)                      w_state_nxt = IDLE;
            default:                                  w_state_nxt = IDLE;
        endcase
        if (w_timeout) w_state_nxt = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shift     <= 8'd0;
            r_bitcnt    <= 3'd0;
            r_parity    <= 1'b0;
            r_ext       <= 1'b0;
            r_brk       <= 1'b0;
            r_tmo       <= '0;
            r_key       <= 11'd0;
            r_key_stb   <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_key_stb   <= 1'b0;
            r_frame_err <= 1'b0;

            if (r_state == IDLE || w_fall)  r_tmo <= '0;
            else if (r_tmo != TW'(TIMEOUT)) r_tmo <= r_tmo + TW'(1);

            if (r_state == IDLE && w_fall && !w_data) begin
                r_shift  <= 8'd0;
                r_bitcnt <= 3'd0;
            end
            if (r_state == DATA && w_fall) begin
                r_shift  <= {w_data, r_shift[7:1]};
                r_bitcnt <= r_bitcnt + 3'd1;
            end
            if (r_state == PARITY && w_fall) r_parity <= w_data;

            // Prefix bytes only arm flags; any other byte publishes and clears them.
            if (w_good) begin
                if (r_shift == PS2_EXT) begin
                    r_ext <= 1'b1;
                end else if (r_shift == PS2_BRK) begin
                    r_brk <= 1'b1;
                end else begin
                    r_key[KEY_TOGGLE]  <= ~r_key[KEY_TOGGLE];
                    r_key[KEY_PRESSED] <= ~r_brk;
                    r_key[KEY_EXT]     <= r_ext;
                    r_key[7:0]         <= r_shift;
                    r_key_stb          <= 1'b1;
                    r_ext              <= 1'b0;
                    r_brk              <= 1'b0;
                end
            end
            if (w_bad || w_timeout) begin
                r_frame_err <= 1'b1;
                r_ext       <= 1'b0;
                r_brk       <= 1'b0;
            end
        end
    end

    assign ps2_key        = r_key;
    assign key_stb        = r_key_stb;
    assign frame_err      = r_frame_err;
    assign o_dbg_state    = r_state;
    assign o_dbg_filt_clk = w_clk_level;

endmodule

// File: tb/tb_ps2_key_rx.sv
// Directed bench for ps2_key_rx: decoded key words, prefix folding, error
// pulses, timeout recovery, glitch rejection and mid-frame reset.
module tb_ps2_key_rx;

    localparam int FILTER_LEN = 4;
    localparam int TIMEOUT    = 200;
    localparam int HALF       = 8;

    logic        clk;
    logic        rst_n;
    logic        ps2_clk;
    logic        ps2_data;
    logic [10:0] ps2_key;
    logic        key_stb;
    logic        frame_err;
    logic [1:0]  dbg_state;
    logic        dbg_filt_clk;

    int n_assert = 0;
    int n_fail   = 0;
    int stb_total  = 0;
    int err_total  = 0;
    int both_total = 0;
    int stb_at;
    int err_at;
    int stb_before;
    int err_before;

    ps2_key_rx #(
        .FILTER_LEN (FILTER_LEN),
        .TIMEOUT    (TIMEOUT)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .ps2_clk        (ps2_clk),
        .ps2_data       (ps2_data),
        .ps2_key        (ps2_key),
        .key_stb        (key_stb),
        .frame_err      (frame_err),
        .o_dbg_state    (dbg_state),
        .o_dbg_filt_clk (dbg_filt_clk)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (key_stb)              stb_total++;
        if (frame_err)            err_total++;
        if (key_stb && frame_err) both_total++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // driver tasks: every task starts and ends 1 time unit after a rising clk edge
    task automatic ps2_bit(input logic b, input logic glitch);
        ps2_data = b;
        repeat (HALF) @(posedge clk);
        #1;
        if (glitch) begin
            ps2_clk = 1'b0;
            repeat (2) @(posedge clk);
            #1 ps2_clk = 1'b1;
            repeat (HALF) @(posedge clk);
            #1;
        end
        ps2_clk = 1'b0;
        repeat (HALF) @(posedge clk);
        #1 ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic flip, input logic glitch);
        ps2_bit(1'b0, glitch);
        for (int i = 0; i < 8; i++) ps2_bit(b[i], glitch);
        ps2_bit((~^b) ^ flip, glitch);
        ps2_data = 1'b1;
        repeat (HALF) @(posedge clk);
        #1 ps2_clk = 1'b0;
        stb_at = 0;
        err_at = 0;
        for (int n = 1; n <= HALF; n++) begin
            @(posedge clk);
            #1;
            if (key_stb && stb_at == 0)   stb_at = n;
            if (frame_err && err_at == 0) err_at = n;
        end
        ps2_clk = 1'b1;
        repeat (2 * HALF) @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n    = 1'b0;
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("reset_key", 32'(ps2_key), 32'h000);
        chk("reset_stb", 32'(key_stb), 32'd0);
        chk("reset_err", 32'(frame_err), 32'd0);
        chk("reset_state", 32'(dbg_state), 32'd0);
        rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;

        send_frame(8'h1C, 1'b0, 1'b0);
        chk("make_1c_key", 32'(ps2_key), 32'h61C);
        chk("make_1c_latency", 32'(stb_at), 32'(FILTER_LEN + 3));
        chk("make_1c_no_err", 32'(err_at), 32'd0);

        stb_before = stb_total;
        send_frame(8'hF0, 1'b0, 1'b0);
        chk("brk_prefix_no_stb", 32'(stb_at), 32'd0);
        send_frame(8'h1C, 1'b0, 1'b0);
        chk("break_1c_key", 32'(ps2_key), 32'h01C);
        chk("break_pair_one_stb", 32'(stb_total - stb_before), 32'd1);

        send_frame(8'hE0, 1'b0, 1'b0);
        send_frame(8'h75, 1'b0, 1'b0);
        chk("ext_make_75", 32'(ps2_key), 32'h775);
        send_frame(8'hE0, 1'b0, 1'b0);
        send_frame(8'hF0, 1'b0, 1'b0);
        send_frame(8'h75, 1'b0, 1'b0);
        chk("ext_break_75", 32'(ps2_key), 32'h175);

        send_frame(8'h29, 1'b1, 1'b0);
        chk("parity_err_latency", 32'(err_at), 32'(FILTER_LEN + 3));
        chk("parity_err_no_stb", 32'(stb_at), 32'd0);
        chk("parity_err_key_kept", 32'(ps2_key), 32'h175);
        send_frame(8'h29, 1'b0, 1'b0);
        chk("good_29_after_err", 32'(ps2_key), 32'h629);

        err_before = err_total;
        ps2_bit(1'b0, 1'b0);
        ps2_bit(1'b1, 1'b0);
        ps2_bit(1'b0, 1'b0);
        ps2_bit(1'b1, 1'b0);
        chk("stalled_in_data", 32'(dbg_state), 32'd1);
        repeat (TIMEOUT + 5) @(posedge clk);
        #1;
        chk("timeout_one_err", 32'(err_total - err_before), 32'd1);
        chk("timeout_idle", 32'(dbg_state), 32'd0);
        chk("timeout_key_kept", 32'(ps2_key), 32'h629);
        send_frame(8'h05, 1'b0, 1'b0);
        chk("after_timeout_05", 32'(ps2_key), 32'h205);

        send_frame(8'h5A, 1'b0, 1'b1);
        chk("glitched_5a", 32'(ps2_key), 32'h65A);

        send_frame(8'hE0, 1'b0, 1'b0);
        ps2_bit(1'b0, 1'b0);
        ps2_bit(1'b1, 1'b0);
        ps2_bit(1'b1, 1'b0);
        ps2_bit(1'b0, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("midframe_reset_key", 32'(ps2_key), 32'h000);
        chk("midframe_reset_state", 32'(dbg_state), 32'd0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        send_frame(8'h1C, 1'b0, 1'b0);
        chk("after_reset_1c_no_ext", 32'(ps2_key), 32'h61C);

        chk("total_key_strobes", 32'(stb_total), 32'd8);
        chk("total_frame_errs", 32'(err_total), 32'd2);
        chk("stb_err_never_together", 32'(both_total), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
